// File: rtl/alu_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// alu_ctrl_fsm
//   Multicycle MIPS control unit. This FSM steps each instruction through
//   FETCH / DECODE / EXEC / MEM / WB. It drives the datapath strobes and the
//   ALU function and sign controls. Branch decisions use ALU Z[0].
//
//   Optional feature macro: EXC_EN
//     defined   : an undefined opcode/funct in EXEC enters the one-cycle EXC
//                 state. EXC jumps to the vector chosen by EXC_VECTOR_SEL and
//                 writes the return address to $31.
//     undefined : an undefined instruction behaves as a NOP (EXEC -> FETCH).
//
// Parameters
//   EXC_VECTOR_SEL  pc_src code driven in the EXC state (EXC_EN builds only)
//
// Ports
//   clk         in   1   clock, rising edge
//   rst_n       in   1   asynchronous reset, active-low
//   instr       in   32  instruction register contents (valid from DECODE)
//   mem_ack     in   1   memory completes the current request this cycle
//   alu_z0      in   1   ALU Z[0], branch compare result in EXEC
//   ir_write    out  1   load IR from memory read data
//   pc_write    out  1   load PC from the pc_src selection
//   pc_src      out  2   0:ALU result 1:ALUOut 2:jump target 3:exc vector
//   mem_req     out  1   memory request, held until mem_ack
//   mem_we      out  1   write qualifier for mem_req
//   iord        out  1   memory address select 0:PC 1:ALUOut
//   reg_write   out  1   register-file write enable
//   reg_dst     out  2   0:rt 1:rd 2:$31
//   mem_to_reg  out  2   0:ALUOut 1:MDR 2:PC
//   alu_src_a   out  1   0:PC 1:rs
//   alu_src_b   out  2   0:rt 1:const 4 2:ext imm 3:imm<<2
//   ALUFun      out  6   ALU function code
//   Sign        out  1   signed arithmetic/compare
//   state       out  3   current state (debug)
// -----------------------------------------------------------------------------
module alu_ctrl_fsm #(
  parameter logic [1:0] EXC_VECTOR_SEL = 2'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ack,
  input  logic        alu_z0,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [5:0]  ALUFun,
  output logic        Sign,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_EXC    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_RALU,
    C_IALU,
    C_BR,
    C_J,
    C_JAL,
    C_LW,
    C_SW,
    C_UNDEF
  } cls_t;

  localparam logic [5:0] F_ADD = 6'b000000;
  localparam logic [5:0] F_SUB = 6'b000001;
  localparam logic [5:0] F_AND = 6'b011000;
  localparam logic [5:0] F_OR  = 6'b011110;
  localparam logic [5:0] F_XOR = 6'b010110;
  localparam logic [5:0] F_NOR = 6'b010001;
  localparam logic [5:0] F_SLL = 6'b100000;
  localparam logic [5:0] F_SRL = 6'b100001;
  localparam logic [5:0] F_SRA = 6'b100011;
  localparam logic [5:0] F_EQ  = 6'b110011;
  localparam logic [5:0] F_NEQ = 6'b110001;
  localparam logic [5:0] F_LT  = 6'b110101;
  localparam logic [5:0] F_LEZ = 6'b111101;
  localparam logic [5:0] F_LTZ = 6'b111011;
  localparam logic [5:0] F_GTZ = 6'b111111;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_rt;
  cls_t       w_cls;
  logic [5:0] w_dec_fun;
  logic       w_dec_sign;

  logic       w_ir_write;
  logic       w_pc_write;
  logic [1:0] w_pc_src;
  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_iord;
  logic       w_reg_write;
  logic [1:0] w_reg_dst;
  logic [1:0] w_mem_to_reg;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [5:0] w_alu_fun;
  logic       w_sign;

  // rs, rd, shamt and the immediate go straight to the datapath.
  logic       w_unused_instr;

  assign w_op           = instr[31:26];
  assign w_rt           = instr[20:16];
  assign w_funct        = instr[5:0];
  assign w_unused_instr = ^{instr[25:21], instr[15:6]};

  // Instruction class plus the ALU function and sign used in EXEC.
  always_comb begin
    w_cls      = C_UNDEF;
    w_dec_fun  = F_ADD;
    w_dec_sign = 1'b1;
    case (w_op)
      6'h00: begin
        w_cls = C_RALU;
        case (w_funct)
          6'h20: w_dec_fun = F_ADD;
          6'h21: begin w_dec_fun = F_ADD; w_dec_sign = 1'b0; end
          6'h22: w_dec_fun = F_SUB;
          6'h23: begin w_dec_fun = F_SUB; w_dec_sign = 1'b0; end
          6'h24: w_dec_fun = F_AND;
          6'h25: w_dec_fun = F_OR;
          6'h26: w_dec_fun = F_XOR;
          6'h27: w_dec_fun = F_NOR;
          6'h2a: w_dec_fun = F_LT;
          6'h2b: begin w_dec_fun = F_LT; w_dec_sign = 1'b0; end
          // The shift amount comes from the shamt field inside the ALU.
          6'h00: w_dec_fun = F_SLL;
          6'h02: w_dec_fun = F_SRL;
          6'h03: w_dec_fun = F_SRA;
          default: w_cls = C_UNDEF;
        endcase
      end
      // REGIMM: only bltz (rt=0) is implemented.
      6'h01: begin
        if (w_rt == 5'd0) begin
          w_cls     = C_BR;
          w_dec_fun = F_LTZ;
        end
      end
      6'h02: w_cls = C_J;
      6'h03: w_cls = C_JAL;
      6'h04: begin w_cls = C_BR;   w_dec_fun = F_EQ;  end
      6'h05: begin w_cls = C_BR;   w_dec_fun = F_NEQ; end
      6'h06: begin w_cls = C_BR;   w_dec_fun = F_LEZ; end
      6'h07: begin w_cls = C_BR;   w_dec_fun = F_GTZ; end
      6'h08: begin w_cls = C_IALU; w_dec_fun = F_ADD; end
      6'h09: begin w_cls = C_IALU; w_dec_fun = F_ADD; w_dec_sign = 1'b0; end
      6'h0a: begin w_cls = C_IALU; w_dec_fun = F_LT;  end
      6'h0b: begin w_cls = C_IALU; w_dec_fun = F_LT;  w_dec_sign = 1'b0; end
      // Logical immediates zero-extend, so they run unsigned.
      6'h0c: begin w_cls = C_IALU; w_dec_fun = F_AND; w_dec_sign = 1'b0; end
      6'h0d: begin w_cls = C_IALU; w_dec_fun = F_OR;  w_dec_sign = 1'b0; end
      6'h0e: begin w_cls = C_IALU; w_dec_fun = F_XOR; w_dec_sign = 1'b0; end
      6'h23: w_cls = C_LW;
      6'h2b: w_cls = C_SW;
      default: w_cls = C_UNDEF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 2'd0;
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_iord       = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 2'd0;
    w_mem_to_reg = 2'd0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'd0;
    w_alu_fun    = F_ADD;
    w_sign       = 1'b0;
    case (r_state)
      // PC+4 is computed while the fetch is outstanding. It is committed only
      // on the ack cycle.
      S_FETCH: begin
        w_mem_req   = 1'b1;
        w_alu_src_b = 2'd1;
        if (mem_ack) begin
          w_ir_write  = 1'b1;
          w_pc_write  = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      // Branch target PC+(imm<<2) is computed speculatively into ALUOut.
      S_DECODE: begin
        w_alu_src_b = 2'd3;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_alu_fun   = w_dec_fun;
        w_sign      = w_dec_sign;
        w_state_nxt = S_FETCH;
        case (w_cls)
          C_RALU: begin
            w_alu_src_a = 1'b1;
            w_state_nxt = S_WB;
          end
          C_IALU: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'd2;
            w_state_nxt = S_WB;
          end
          C_BR: begin
            w_alu_src_a = 1'b1;
            if (alu_z0) begin
              w_pc_write = 1'b1;
              w_pc_src   = 2'd1;
            end
          end
          C_J: begin
            w_pc_write = 1'b1;
            w_pc_src   = 2'd2;
          end
          C_JAL: begin
            w_pc_write   = 1'b1;
            w_pc_src     = 2'd2;
            w_reg_write  = 1'b1;
            w_reg_dst    = 2'd2;
            w_mem_to_reg = 2'd2;
          end
          C_LW, C_SW: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'd2;
            w_state_nxt = S_MEM;
          end
          default: begin
`ifdef EXC_EN
            w_state_nxt = S_EXC;
`else
            w_state_nxt = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        w_mem_we  = (w_cls == C_SW);
        if (mem_ack) w_state_nxt = (w_cls == C_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = (w_cls == C_RALU) ? 2'd1 : 2'd0;
        w_mem_to_reg = (w_cls == C_LW) ? 2'd1 : 2'd0;
        w_state_nxt  = S_FETCH;
      end
`ifdef EXC_EN
      S_EXC: begin
        w_pc_write   = 1'b1;
        w_pc_src     = EXC_VECTOR_SEL;
        w_reg_write  = 1'b1;
        w_reg_dst    = 2'd2;
        w_mem_to_reg = 2'd2;
        w_state_nxt  = S_FETCH;
      end
`endif
      default: w_state_nxt = S_FETCH;
    endcase
  end

`ifndef EXC_EN
  logic w_unused_exc_vec;
  assign w_unused_exc_vec = ^EXC_VECTOR_SEL;
`endif

  // Outputs are forced low while reset is asserted. An outstanding memory
  // request is therefore withdrawn the moment rst_n falls, without waiting
  // for a clock.
  assign ir_write   = rst_n & w_ir_write;
  assign pc_write   = rst_n & w_pc_write;
  assign pc_src     = rst_n ? w_pc_src     : 2'd0;
  assign mem_req    = rst_n & w_mem_req;
  assign mem_we     = rst_n & w_mem_we;
  assign iord       = rst_n & w_iord;
  assign reg_write  = rst_n & w_reg_write;
  assign reg_dst    = rst_n ? w_reg_dst    : 2'd0;
  assign mem_to_reg = rst_n ? w_mem_to_reg : 2'd0;
  assign alu_src_a  = rst_n & w_alu_src_a;
  assign alu_src_b  = rst_n ? w_alu_src_b  : 2'd0;
  assign ALUFun     = rst_n ? w_alu_fun    : 6'd0;
  assign Sign       = rst_n & w_sign;
  assign state      = r_state;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
module tb_alu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ack;
  logic        alu_z0;
  logic        ir_write, pc_write, mem_req, mem_we, iord, reg_write;
  logic        alu_src_a, Sign;
  logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [5:0]  ALUFun;
  logic [2:0]  state;

  always #5 clk = ~clk;

  alu_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ack(mem_ack), .alu_z0(alu_z0),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .mem_req(mem_req),
    .mem_we(mem_we), .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ALUFun(ALUFun), .Sign(Sign), .state(state)
  );

  localparam int F_STATE = 0, F_IRW = 1, F_PCW = 2, F_PCSRC = 3, F_MREQ = 4,
                 F_MWE = 5, F_IORD = 6, F_RW = 7, F_RDST = 8, F_M2R = 9,
                 F_SRCA = 10, F_SRCB = 11, F_FUN = 12, F_SIGN = 13;

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_SLTU = 32'h0022182B;
  localparam logic [31:0] I_SRA  = 32'h00021903;
  localparam logic [31:0] I_ANDI = 32'h30220005;
  localparam logic [31:0] I_BEQ  = 32'h10220004;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_LW   = 32'h8C220008;
  localparam logic [31:0] I_SW   = 32'hAC220008;
  localparam logic [31:0] I_BAD  = 32'hFC000000;

  typedef struct {
    int          fld;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] obs(int f);
    case (f)
      F_STATE: return {29'd0, state};
      F_IRW:   return {31'd0, ir_write};
      F_PCW:   return {31'd0, pc_write};
      F_PCSRC: return {30'd0, pc_src};
      F_MREQ:  return {31'd0, mem_req};
      F_MWE:   return {31'd0, mem_we};
      F_IORD:  return {31'd0, iord};
      F_RW:    return {31'd0, reg_write};
      F_RDST:  return {30'd0, reg_dst};
      F_M2R:   return {30'd0, mem_to_reg};
      F_SRCA:  return {31'd0, alu_src_a};
      F_SRCB:  return {30'd0, alu_src_b};
      F_FUN:   return {26'd0, ALUFun};
      F_SIGN:  return {31'd0, Sign};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int f, input logic [31:0] v);
    exp_t e;
    e.fld = f;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Let combinational outputs settle, then drain the scoreboard.
  task automatic check_now();
    exp_t e;
    logic [31:0] o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.fld);
      checks++;
      assert (o === e.val)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_fetch(input string t);
    push({t, "_fetch_state"}, F_STATE, 0);
    push({t, "_fetch_irw"},   F_IRW,   1);
    push({t, "_fetch_pcw"},   F_PCW,   1);
    push({t, "_fetch_pcsrc"}, F_PCSRC, 0);
    push({t, "_fetch_mreq"},  F_MREQ,  1);
    push({t, "_fetch_iord"},  F_IORD,  0);
    push({t, "_fetch_srcb"},  F_SRCB,  1);
    push({t, "_fetch_fun"},   F_FUN,   0);
    check_now();
    tick();
  endtask

  task automatic do_decode(input string t);
    push({t, "_dec_state"}, F_STATE, 1);
    push({t, "_dec_srca"},  F_SRCA,  0);
    push({t, "_dec_srcb"},  F_SRCB,  3);
    push({t, "_dec_fun"},   F_FUN,   0);
    push({t, "_dec_mreq"},  F_MREQ,  0);
    push({t, "_dec_pcw"},   F_PCW,   0);
    check_now();
    tick();
  endtask

  task automatic do_exec_r(input string t, input logic [5:0] fun, input logic sgn);
    push({t, "_ex_state"}, F_STATE, 2);
    push({t, "_ex_fun"},   F_FUN,   {26'd0, fun});
    push({t, "_ex_sign"},  F_SIGN,  {31'd0, sgn});
    push({t, "_ex_srca"},  F_SRCA,  1);
    push({t, "_ex_srcb"},  F_SRCB,  0);
    push({t, "_ex_rw"},    F_RW,    0);
    check_now();
    tick();
  endtask

  task automatic do_wb(input string t, input logic [1:0] rd, input logic [1:0] m2r);
    push({t, "_wb_state"}, F_STATE, 4);
    push({t, "_wb_rw"},    F_RW,    1);
    push({t, "_wb_rdst"},  F_RDST,  {30'd0, rd});
    push({t, "_wb_m2r"},   F_M2R,   {30'd0, m2r});
    push({t, "_wb_pcw"},   F_PCW,   0);
    check_now();
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    mem_ack = 1'b1;
    alu_z0  = 1'b0;
    instr   = I_ADD;

    // Reset: every output low even with mem_ack high.
    for (int f = F_STATE; f <= F_SIGN; f++) push("reset_out", f, 0);
    check_now();
    tick();
    tick();
    rst_n = 1'b1;

    // add: FETCH, DECODE, EXEC, WB
    do_fetch("add");
    do_decode("add");
    do_exec_r("add", 6'b000000, 1'b1);
    do_wb("add", 2'd1, 2'd0);

    instr = I_SLTU;
    do_fetch("sltu");
    do_decode("sltu");
    do_exec_r("sltu", 6'b110101, 1'b0);
    do_wb("sltu", 2'd1, 2'd0);

    instr = I_SRA;
    do_fetch("sra");
    do_decode("sra");
    do_exec_r("sra", 6'b100011, 1'b1);
    do_wb("sra", 2'd1, 2'd0);

    instr = I_ANDI;
    do_fetch("andi");
    do_decode("andi");
    push("andi_ex_fun",  F_FUN,  32'h18);
    push("andi_ex_sign", F_SIGN, 0);
    push("andi_ex_srcb", F_SRCB, 2);
    check_now();
    tick();
    do_wb("andi", 2'd0, 2'd0);

    // beq taken
    instr  = I_BEQ;
    alu_z0 = 1'b1;
    do_fetch("beq1");
    do_decode("beq1");
    push("beq1_ex_state", F_STATE, 2);
    push("beq1_ex_fun",   F_FUN,   32'h33);
    push("beq1_ex_pcw",   F_PCW,   1);
    push("beq1_ex_pcsrc", F_PCSRC, 1);
    check_now();
    tick();

    // beq not taken; next state is FETCH (checked by the following fetch)
    alu_z0 = 1'b0;
    do_fetch("beq0");
    do_decode("beq0");
    push("beq0_ex_fun", F_FUN, 32'h33);
    push("beq0_ex_pcw", F_PCW, 0);
    check_now();
    tick();

    instr = I_J;
    do_fetch("j");
    do_decode("j");
    push("j_ex_pcw",   F_PCW,   1);
    push("j_ex_pcsrc", F_PCSRC, 2);
    push("j_ex_rw",    F_RW,    0);
    check_now();
    tick();

    instr = I_JAL;
    do_fetch("jal");
    do_decode("jal");
    push("jal_ex_pcw",   F_PCW,   1);
    push("jal_ex_pcsrc", F_PCSRC, 2);
    push("jal_ex_rw",    F_RW,    1);
    push("jal_ex_rdst",  F_RDST,  2);
    push("jal_ex_m2r",   F_M2R,   2);
    check_now();
    tick();

    instr = I_SW;
    do_fetch("sw");
    do_decode("sw");
    push("sw_ex_state", F_STATE, 2);
    push("sw_ex_fun",   F_FUN,   0);
    push("sw_ex_srca",  F_SRCA,  1);
    push("sw_ex_srcb",  F_SRCB,  2);
    push("sw_ex_mreq",  F_MREQ,  0);
    check_now();
    tick();
    push("sw_mem_state", F_STATE, 3);
    push("sw_mem_mreq",  F_MREQ,  1);
    push("sw_mem_we",    F_MWE,   1);
    push("sw_mem_iord",  F_IORD,  1);
    check_now();
    tick();

    // lw: one FETCH wait cycle, then three MEM wait cycles
    instr   = I_LW;
    mem_ack = 1'b0;
    push("lw_fwait_state", F_STATE, 0);
    push("lw_fwait_mreq",  F_MREQ,  1);
    push("lw_fwait_irw",   F_IRW,   0);
    push("lw_fwait_pcw",   F_PCW,   0);
    check_now();
    tick();
    mem_ack = 1'b1;
    do_fetch("lw");
    do_decode("lw");
    push("lw_ex_state", F_STATE, 2);
    push("lw_ex_srcb",  F_SRCB,  2);
    check_now();
    tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ack = 1'b1;
      push("lw_mem_state", F_STATE, 3);
      push("lw_mem_mreq",  F_MREQ,  1);
      push("lw_mem_iord",  F_IORD,  1);
      push("lw_mem_we",    F_MWE,   0);
      check_now();
      tick();
    end
    do_wb("lw", 2'd0, 2'd1);

    // lw interrupted by reset during the MEM wait
    do_fetch("lwr");
    do_decode("lwr");
    tick();
    mem_ack = 1'b0;
    push("lwr_mem_mreq", F_MREQ, 1);
    check_now();
    #1;
    rst_n = 1'b0;
    push("lwr_rst_state", F_STATE, 0);
    push("lwr_rst_mreq",  F_MREQ,  0);
    push("lwr_rst_iord",  F_IORD,  0);
    check_now();
    tick();
    rst_n   = 1'b1;
    mem_ack = 1'b1;

    // Undefined opcode
    instr = I_BAD;
    do_fetch("bad");
    do_decode("bad");
    push("bad_ex_state", F_STATE, 2);
    push("bad_ex_pcw",   F_PCW,   0);
    push("bad_ex_rw",    F_RW,    0);
    push("bad_ex_mreq",  F_MREQ,  0);
    check_now();
    tick();
`ifdef EXC_EN
    push("exc_state", F_STATE, 5);
    push("exc_pcw",   F_PCW,   1);
    push("exc_pcsrc", F_PCSRC, 3);
    push("exc_rw",    F_RW,    1);
    push("exc_rdst",  F_RDST,  2);
    push("exc_m2r",   F_M2R,   2);
    check_now();
    tick();
`endif
    instr = I_ADD;
    do_fetch("after_bad");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
